req_arbiter8: RTL and testbench

- Registered 8-way arbiter that shares one datapath resource among eight requesters, e.g. a shared adder or a result bus fed through an 8:1 select.
- Outputs a one-hot grant plus a 3-bit grant index; the index drives the resource's 8:1 select control directly.
- Default policy is fixed priority, index 7 highest. Grants are held until the owner releases, or until a hold-limit timeout forces re-arbitration.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_pick.sv | 45 ++++
 rtl/req_arbiter8.sv | 78 +++++++
 tb/tb_req_arbiter8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encodings and helpers for the req_arbiter8 slice.
// Build option ARB_ROUND_ROBIN_EN (in arb_pick) switches to rotating priority.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Expand a binary requester index into a one-hot grant vector.
  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the 8-way arbiter.
// Macro ARB_ROUND_ROBIN_EN: when defined, the search starts just below
// last_idx and wraps, with last_idx itself searched last; when undefined,
// the highest set index wins and last_idx is ignored.
module arb_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     cand,
  input  logic [ARB_IDX_W-1:0] last_idx,
  output logic [ARB_IDX_W-1:0] win_idx,
  output logic                 win_any
);

  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] enc;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2*ARB_N-1:0] dbl;

  // Rotate so bit j holds requester (last_idx + j) mod 8; bit 7 is then last_idx-1.
  always_comb begin
    dbl = {cand, cand} >> last_idx;
    rot = dbl[ARB_N-1:0];
  end

  assign win_idx = enc + last_idx;
`else
  logic unused_last;

  assign unused_last = ^last_idx;
  assign rot         = cand;
  assign win_idx     = enc;
`endif

  // Priority encode: the highest set bit of the rotated vector wins.
  always_comb begin
    enc = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (rot[i]) enc = ARB_IDX_W'(i);
    end
  end

  assign win_any = |cand;

endmodule

// File: rtl/req_arbiter8.sv
// Registered 8-way arbiter: grants are held until the owner releases (done,
// dropped request, or hold-limit timeout) and then handed over with no bubble.
// Priority policy is selected in arb_pick by macro ARB_ROUND_ROBIN_EN.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ARB_N-1:0]     req,
  input  logic                 done,
  output logic [ARB_N-1:0]     grant,
  output logic [ARB_IDX_W-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  logic [0:0]           state;
  logic [CNT_W-1:0]     hold_cnt;
  logic [ARB_IDX_W-1:0] last_idx;
  logic [ARB_N-1:0]     cand;
  logic [ARB_IDX_W-1:0] win_idx;
  logic                 win_any;
  logic                 rel_now;

  // Exclude the current owner so others get a turn; fall back to all requests.
  always_comb begin
    cand = req & ~grant;
    if (cand == '0) cand = req;
  end

  // Owner gives up the grant on done, on dropping its request, or at the hold limit.
  always_comb begin
    rel_now = done || !req[grant_idx] ||
              ((HOLD_MAX != 0) && (hold_cnt == HOLD_LAST));
  end

  arb_pick u_pick (
    .cand     (cand),
    .last_idx (last_idx),
    .win_idx  (win_idx),
    .win_any  (win_any)
  );

  // FSM, hold counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      last_idx    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else if (state == ST_IDLE || rel_now) begin
      if (win_any) begin
        state       <= ST_BUSY;
        hold_cnt    <= '0;
        last_idx    <= win_idx;
        grant       <= onehot8(win_idx);
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
      end else begin
        state       <= ST_IDLE;
        hold_cnt    <= '0;
        grant       <= '0;
        grant_idx   <= '0;
        grant_valid <= 1'b0;
      end
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed self-checking bench for req_arbiter8. Instance dut uses a hold
// limit of 4, instance dut0 has the timeout disabled; both share inputs.
module tb_req_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant,  grant0;
  logic [2:0] grant_idx, grant_idx0;
  logic       grant_valid, grant_valid0;

  int checks;
  int errors;

  req_arbiter8 #(.HOLD_MAX(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  req_arbiter8 #(.HOLD_MAX(0), .CNT_W(5)) dut0 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant0), .grant_idx(grant_idx0), .grant_valid(grant_valid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00; done = 1'b0;
    tick(); tick();
    checks++;
    if ({grant_valid, grant_idx, grant} !== 12'h000) begin
      $display("[TB] FAIL reset_outputs got v=%b idx=%0d g=%b want all zero",
               grant_valid, grant_idx, grant);
      errors++;
    end
    checks++;
    if ({grant_valid0, grant_idx0, grant0} !== 12'h000) begin
      $display("[TB] FAIL reset_outputs0 got v=%b idx=%0d g=%b want all zero",
               grant_valid0, grant_idx0, grant0);
      errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_first_grant();
    req = 8'b1010_0000;
    tick();
    checks++;
    if (grant !== 8'b1000_0000) begin
      $display("[TB] FAIL first_grant got %b want 10000000", grant); errors++;
    end
    checks++;
    if (grant_idx !== 3'd7) begin
      $display("[TB] FAIL first_idx got %0d want 7", grant_idx); errors++;
    end
    checks++;
    if (grant_valid !== 1'b1) begin
      $display("[TB] FAIL first_valid got %b want 1", grant_valid); errors++;
    end
  endtask

  task automatic test_done_handoff();
    logic [2:0] exp2;
`ifdef ARB_ROUND_ROBIN_EN
    exp2 = 3'd2;
`else
    exp2 = 3'd7;
`endif
    req = 8'b1010_0100; done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (grant_idx !== 3'd5 || grant !== 8'b0010_0000) begin
      $display("[TB] FAIL handoff_1 got idx=%0d g=%b want idx=5", grant_idx, grant);
      errors++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (grant_idx !== exp2 || grant !== (8'h01 << exp2)) begin
      $display("[TB] FAIL handoff_2 got idx=%0d g=%b want idx=%0d", grant_idx, grant, exp2);
      errors++;
    end
  endtask

  task automatic test_hold_timeout();
    logic [2:0] exp_seq [9];
    exp_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    reset = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    reset = 1'b0; req = 8'b0000_0011;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (grant_idx !== exp_seq[i] || grant_valid !== 1'b1) begin
        $display("[TB] FAIL timeout_seq[%0d] got idx=%0d v=%b want idx=%0d v=1",
                 i, grant_idx, grant_valid, exp_seq[i]);
        errors++;
      end
      checks++;
      if (grant_idx0 !== 3'd1 || grant0 !== 8'b0000_0010) begin
        $display("[TB] FAIL no_timeout[%0d] got idx=%0d g=%b want idx=1",
                 i, grant_idx0, grant0);
        errors++;
      end
    end
  endtask

  task automatic test_drop_to_idle();
    reset = 1'b1; req = 8'h00;
    tick();
    reset = 1'b0; req = 8'h08;
    tick();
    checks++;
    if (grant_idx !== 3'd3 || grant !== 8'h08) begin
      $display("[TB] FAIL owner3 got idx=%0d g=%b want idx=3", grant_idx, grant); errors++;
    end
    req = 8'h00;
    tick();
    checks++;
    if ({grant_valid, grant_idx, grant} !== 12'h000) begin
      $display("[TB] FAIL drop_idle got v=%b idx=%0d g=%b want all zero",
               grant_valid, grant_idx, grant);
      errors++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if ({grant_valid, grant_idx, grant} !== 12'h000) begin
      $display("[TB] FAIL idle_done got v=%b idx=%0d g=%b want all zero",
               grant_valid, grant_idx, grant);
      errors++;
    end
    req = 8'h01;
    tick();
    checks++;
    if ({grant_valid, grant_idx, grant} !== {1'b1, 3'd0, 8'h01}) begin
      $display("[TB] FAIL regrant0 got v=%b idx=%0d g=%b want v=1 idx=0 g=00000001",
               grant_valid, grant_idx, grant);
      errors++;
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 8'hFF; reset = 1'b1;
    tick();
    checks++;
    if ({grant_valid, grant_idx, grant} !== 12'h000) begin
      $display("[TB] FAIL mid_reset got v=%b idx=%0d g=%b want all zero",
               grant_valid, grant_idx, grant);
      errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (grant_idx !== 3'd7 || grant !== 8'h80 || grant_valid !== 1'b1) begin
      $display("[TB] FAIL post_reset got idx=%0d g=%b v=%b want idx=7",
               grant_idx, grant, grant_valid);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    req = 8'hFF; done = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp = 3'(6 - i);
`else
      exp = (i % 2 == 0) ? 3'd6 : 3'd7;
`endif
      tick();
      checks++;
      if (grant_idx !== exp || grant !== (8'h01 << exp) || grant_valid !== 1'b1) begin
        $display("[TB] FAIL b2b[%0d] got idx=%0d g=%b v=%b want idx=%0d",
                 i, grant_idx, grant, grant_valid, exp);
        errors++;
      end
    end
    done = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_first_grant();
    test_done_handoff();
    test_hold_timeout();
    test_drop_to_idle();
    test_reset_mid_grant();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
